// File: rtl/mac_rr_scheduler.sv
// Round-robin scheduler that time-shares one MAC datapath among NUM_REQ requesters.
// Optional watchdog on the WAIT state is enabled by defining MAC_WATCHDOG_EN.
module mac_rr_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int CNT_W      = 4,
    parameter int SEL_W      = $clog2(NUM_REQ),
    parameter int WDOG_LIMIT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       grant,
    output logic [SEL_W-1:0]         sel,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic                     mac_clear,
    output logic                     load_op,
    output logic                     begin_mul,
    input  logic                     end_mul,
    output logic                     add,
    output logic                     err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_ADD   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]         state_reg;
    logic [NUM_REQ-1:0] grant_reg;
    logic [SEL_W-1:0]   sel_reg;
    logic [SEL_W-1:0]   last_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   len_arr [NUM_REQ];
    logic [SEL_W-1:0]   winner;
    logic [SEL_W-1:0]   idx;
    logic               valid_busy;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_len
        assign len_arr[gi] = req_len[gi*CNT_W +: CNT_W];
    end

    // Scan from the farthest candidate back to last+1 so the nearest set request wins.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = SEL_W'((int'(last_reg) + k) % NUM_REQ);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

`ifdef MAC_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_LIMIT + 1);
    logic [WD_W-1:0] wcnt_reg;
    logic            abort_reg;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            grant_reg <= '0;
            sel_reg   <= '0;
            last_reg  <= SEL_W'(NUM_REQ - 1);
            cnt_reg   <= '0;
`ifdef MAC_WATCHDOG_EN
            wcnt_reg  <= '0;
            abort_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    grant_reg <= '0;
                    if (|req) begin
                        sel_reg   <= winner;
                        grant_reg <= NUM_REQ'(1) << winner;
                        cnt_reg   <= len_arr[winner];
                        last_reg  <= winner;
                        state_reg <= S_CLEAR;
`ifdef MAC_WATCHDOG_EN
                        abort_reg <= 1'b0;
`endif
                    end
                end
                S_CLEAR: state_reg <= S_LOAD;
                S_LOAD:  state_reg <= S_RUN;
                S_RUN: begin
                    state_reg <= S_WAIT;
`ifdef MAC_WATCHDOG_EN
                    wcnt_reg  <= '0;
`endif
                end
                S_WAIT: begin
                    if (end_mul) begin
                        state_reg <= S_ADD;
`ifdef MAC_WATCHDOG_EN
                    end else if (wcnt_reg == WD_W'(WDOG_LIMIT - 1)) begin
                        state_reg <= S_DONE;
                        abort_reg <= 1'b1;
                    end else begin
                        wcnt_reg  <= wcnt_reg + 1'b1;
`endif
                    end
                end
                S_ADD: begin
                    if (cnt_reg == '0) begin
                        state_reg <= S_DONE;
                    end else begin
                        cnt_reg   <= cnt_reg - 1'b1;
                        state_reg <= S_LOAD;
                    end
                end
                S_DONE: begin
                    grant_reg <= '0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    grant_reg <= '0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Decoded outputs are gated by a legal busy state so an illegal encoding shows all zeros.
    assign valid_busy = (state_reg != S_IDLE) && (state_reg <= S_DONE);
    assign busy       = valid_busy;
    assign grant      = valid_busy ? grant_reg : '0;
    assign sel        = valid_busy ? sel_reg : '0;
    assign done       = (state_reg == S_DONE) ? grant_reg : '0;
    assign mac_clear  = (state_reg == S_CLEAR);
    assign load_op    = (state_reg == S_LOAD);
    assign begin_mul  = (state_reg == S_RUN);
    assign add        = (state_reg == S_ADD);

`ifdef MAC_WATCHDOG_EN
    assign err = (state_reg == S_DONE) && abort_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mac_rr_scheduler.sv
// Directed testbench for mac_rr_scheduler: arbitration order, sequencing, latency and reset.
// The watchdog scenario adapts to whether MAC_WATCHDOG_EN is defined.
module tb_mac_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 4;
    localparam int SEL_W   = 2;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic [NUM_REQ-1:0]       req = '0;
    logic [NUM_REQ*CNT_W-1:0] req_len = '0;
    logic [NUM_REQ-1:0]       grant;
    logic [SEL_W-1:0]         sel;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic                     mac_clear;
    logic                     load_op;
    logic                     begin_mul;
    logic                     end_mul = 1'b0;
    logic                     add;
    logic                     err;

    int tests_run = 0;
    int tests_failed = 0;

    // end_mul mode: 0 = high two cycles after begin_mul, 1 = tied high, 2 = held low
    int em_mode = 0;
    int cd = 0;
    bit auto_drop = 1'b1;
    int n_clear, n_load, n_mul, n_add, n_done, n_err;
    int order_q[$];

    mac_rr_scheduler #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .SEL_W(SEL_W), .WDOG_LIMIT(16)) dut (
        .clk(clk), .reset(reset), .req(req), .req_len(req_len), .grant(grant), .sel(sel),
        .done(done), .busy(busy), .mac_clear(mac_clear), .load_op(load_op),
        .begin_mul(begin_mul), .end_mul(end_mul), .add(add), .err(err)
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge, tally strobes, and drive end_mul / req handshake.
    task automatic step();
        @(negedge clk);
        if (mac_clear) n_clear++;
        if (load_op)   n_load++;
        if (begin_mul) n_mul++;
        if (add)       n_add++;
        if (err)       n_err++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (done[i]) begin
                order_q.push_back(i);
                n_done++;
                $display("[TB] t=%0t done[%0d] err=%0b", $time, i, err);
                if (auto_drop) req[i] = 1'b0;
            end
        end
        case (em_mode)
            1: end_mul = 1'b1;
            2: end_mul = 1'b0;
            default: begin
                if (begin_mul) begin
                    cd = 2;
                    end_mul = 1'b0;
                end else if (cd > 0) begin
                    cd--;
                    end_mul = (cd == 0);
                end else begin
                    end_mul = 1'b0;
                end
            end
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req = '0;
        req_len = '0;
        end_mul = 1'b0;
        cd = 0;
        n_clear = 0; n_load = 0; n_mul = 0; n_add = 0; n_done = 0; n_err = 0;
        order_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({grant, sel, done, busy, mac_clear, load_op, begin_mul, add, err} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got grant=%b sel=%0d done=%b busy=%b strobes=%b%b%b%b err=%b, expected all 0",
                     grant, sel, done, busy, mac_clear, load_op, begin_mul, add, err);
        end
    endtask

    task automatic test_single_job();
        int bad_owner;
        do_reset();
        em_mode = 0; auto_drop = 1'b1;
        req_len[0 +: CNT_W] = 4'd9;
        req = 4'b0001;
        bad_owner = 0;
        for (int k = 0; k < 300 && n_done < 1; k++) begin
            step();
            if (busy && (grant !== 4'b0001 || sel !== 2'd0)) bad_owner++;
        end
        tests_run++;
        if (n_done != 1 || order_q.size() != 1 || order_q[0] != 0) begin
            tests_failed++;
            $display("FAIL single_done: got %0d done pulses, expected one on requester 0", n_done);
        end
        tests_run++;
        if (n_clear != 1 || n_load != 10 || n_mul != 10 || n_add != 10) begin
            tests_failed++;
            $display("FAIL single_counts: got clear=%0d load=%0d mul=%0d add=%0d, expected 1/10/10/10",
                     n_clear, n_load, n_mul, n_add);
        end
        tests_run++;
        if (bad_owner != 0) begin
            tests_failed++;
            $display("FAIL single_owner: got %0d cycles with wrong grant/sel, expected 0", bad_owner);
        end
        step();
        tests_run++;
        if (busy !== 1'b0 || grant !== 4'b0000 || n_done != 1) begin
            tests_failed++;
            $display("FAIL single_idle: got busy=%b grant=%b dones=%0d, expected 0/0000/1", busy, grant, n_done);
        end
    endtask

    task automatic test_latency();
        logic [NUM_REQ-1:0] g [8];
        logic [NUM_REQ-1:0] d [8];
        logic               a [8];
        logic               b [8];
        do_reset();
        em_mode = 1; auto_drop = 1'b1;
        end_mul = 1'b1;
        req_len[1*CNT_W +: CNT_W] = 4'd0;
        req = 4'b0010;
        for (int k = 1; k <= 7; k++) begin
            step();
            g[k] = grant; d[k] = done; a[k] = add; b[k] = busy;
        end
        tests_run++;
        if (g[1] !== 4'b0010) begin
            tests_failed++;
            $display("FAIL latency_grant: got grant=%b at t+1, expected 0010", g[1]);
        end
        tests_run++;
        if (a[5] !== 1'b1 || a[4] !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_add: got add t+4=%b t+5=%b, expected 0 then 1", a[4], a[5]);
        end
        tests_run++;
        if (d[6] !== 4'b0010 || d[5] !== 4'b0000) begin
            tests_failed++;
            $display("FAIL latency_done: got done t+5=%b t+6=%b, expected 0000 then 0010", d[5], d[6]);
        end
        tests_run++;
        if (b[7] !== 1'b0 || b[6] !== 1'b1 || g[7] !== 4'b0000) begin
            tests_failed++;
            $display("FAIL latency_busy: got busy t+6=%b t+7=%b grant t+7=%b, expected 1/0/0000", b[6], b[7], g[7]);
        end
    endtask

    task automatic test_fairness();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        em_mode = 1; auto_drop = 1'b1;
        req = 4'b0101;
        for (int k = 0; k < 60 && order_q.size() < 2; k++) step();
        tests_run++;
        if (order_q.size() != 2 || order_q[0] != 0 || order_q[1] != 2) begin
            tests_failed++;
            $display("FAIL fair_pair: got %0d jobs first=%0d, expected order 0 then 2",
                     order_q.size(), order_q.size() > 0 ? order_q[0] : -1);
        end
        do_reset();
        em_mode = 1; auto_drop = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 100 && order_q.size() < 5; k++) step();
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (order_q.size() <= i || order_q[i] != exp_order[i]) begin
                tests_failed++;
                $display("FAIL fair_all[%0d]: got requester %0d, expected %0d",
                         i, order_q.size() > i ? order_q[i] : -1, exp_order[i]);
            end
        end
        auto_drop = 1'b1;
    endtask

    task automatic test_reset_mid_job();
        do_reset();
        em_mode = 2; auto_drop = 1'b1;
        req_len[2*CNT_W +: CNT_W] = 4'd3;
        req = 4'b0100;
        for (int k = 0; k < 10 && !begin_mul; k++) step();
        step();
        tests_run++;
        if (busy !== 1'b1 || grant !== 4'b0100 || sel !== 2'd2) begin
            tests_failed++;
            $display("FAIL midreset_pre: got busy=%b grant=%b sel=%0d, expected 1/0100/2", busy, grant, sel);
        end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if ({grant, sel, done, busy, mac_clear, load_op, begin_mul, add, err} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_async: got grant=%b sel=%0d busy=%b, expected all outputs 0", grant, sel, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        req = 4'b1111;
        em_mode = 1;
        for (int k = 0; k < 5 && grant == '0; k++) step();
        tests_run++;
        if (grant !== 4'b0001) begin
            tests_failed++;
            $display("FAIL midreset_first: got grant=%b, expected 0001", grant);
        end
    endtask

    task automatic test_late_and_drop();
        do_reset();
        em_mode = 0; auto_drop = 1'b1;
        req_len[1*CNT_W +: CNT_W] = 4'd1;
        req_len[3*CNT_W +: CNT_W] = 4'd0;
        req = 4'b0010;
        for (int k = 0; k < 10 && !load_op; k++) step();
        req[1] = 1'b0;
        req[3] = 1'b1;
        for (int k = 0; k < 80 && order_q.size() < 2; k++) step();
        tests_run++;
        if (order_q.size() != 2 || order_q[0] != 1 || order_q[1] != 3) begin
            tests_failed++;
            $display("FAIL late_order: got %0d jobs first=%0d, expected order 1 then 3",
                     order_q.size(), order_q.size() > 0 ? order_q[0] : -1);
        end
        tests_run++;
        if (n_add != 3) begin
            tests_failed++;
            $display("FAIL late_adds: got %0d add pulses, expected 3", n_add);
        end
    endtask

    task automatic test_watchdog();
        int k_done;
        do_reset();
        em_mode = 2; auto_drop = 1'b1;
        req_len[0 +: CNT_W] = 4'd2;
        req = 4'b0001;
        for (int k = 0; k < 10 && !begin_mul; k++) step();
`ifdef MAC_WATCHDOG_EN
        k_done = -1;
        for (int k = 1; k <= 40 && k_done < 0; k++) begin
            step();
            if (done != '0) begin
                k_done = k;
                tests_run++;
                if (err !== 1'b1 || done !== 4'b0001) begin
                    tests_failed++;
                    $display("FAIL wdog_err: got err=%b done=%b, expected 1/0001", err, done);
                end
            end
        end
        tests_run++;
        if (k_done != 17 || n_add != 0) begin
            tests_failed++;
            $display("FAIL wdog_timing: got done %0d cycles after begin_mul with %0d adds, expected 17 and 0",
                     k_done, n_add);
        end
`else
        k_done = 0;
        repeat (40) step();
        tests_run++;
        if (busy !== 1'b1 || n_err != 0 || n_add != 0 || n_done != 0) begin
            tests_failed++;
            $display("FAIL wdog_off_wait: got busy=%b errs=%0d adds=%0d dones=%0d, expected 1/0/0/0",
                     busy, n_err, n_add, n_done);
        end
        em_mode = 1;
        for (int k = 0; k < 40 && n_done < 1; k++) step();
        tests_run++;
        if (n_done != 1 || n_add != 3 || k_done != 0) begin
            tests_failed++;
            $display("FAIL wdog_off_resume: got dones=%0d adds=%0d, expected 1/3", n_done, n_add);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_latency();
        test_fairness();
        test_reset_mid_job();
        test_late_and_drop();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mac_rr_scheduler.md
Name: mac_rr_scheduler

Overview:
Shares one MAC datapath (multiplier plus accumulator) among NUM_REQ requesters. Round-robin arbitration selects a job, then the block sequences the datapath through clear, load, multiply, wait and accumulate for the job's programmed iteration count. It drives the operand/result mux select and returns a per-requester done pulse. It sits between the requester ports and the shared MAC datapath, replacing a single-owner MAC controller.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CNT_W, 4, width of per-job iteration count
SEL_W, $clog2(NUM_REQ), width of the requester select
WDOG_LIMIT, 16, watchdog limit in cycles (used only with MAC_WATCHDOG_EN)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester job request, level, held until done
req_len  in  NUM_REQ*CNT_W  per-requester iterations minus 1; slice i = [i*CNT_W +: CNT_W]
grant  out  NUM_REQ  one-hot owner of the datapath
sel  out  SEL_W  binary index of the owner, drives the datapath mux
done  out  NUM_REQ  one-cycle completion pulse to the owner
busy  out  1  state != IDLE
mac_clear  out  1  one-cycle accumulator clear pulse
load_op  out  1  one-cycle operand load pulse
begin_mul  out  1  one-cycle multiply start pulse
end_mul  in  1  multiplier finished, sampled only in WAIT
add  out  1  one-cycle accumulate pulse
err  out  1  watchdog abort pulse; tied 0 without MAC_WATCHDOG_EN

Behaviour:
- Reset (asynchronous, active-high, effective immediately mid-operation): state=IDLE; grant, done, sel, mac_clear, load_op, begin_mul, add and err are 0; busy=0; iteration counter=0; round-robin pointer last=NUM_REQ-1, so requester 0 has top priority.
- States: IDLE, CLEAR, LOAD, RUN, WAIT, ADD, DONE.
  - IDLE, if |req: the winner is the first set req index searching last+1, last+2, ... modulo NUM_REQ. Latch sel=winner, grant=onehot(winner), cnt=req_len slice of winner, last=winner; go to CLEAR. Otherwise stay in IDLE.
  - CLEAR: mac_clear=1; go to LOAD.
  - LOAD: load_op=1; go to RUN.
  - RUN: begin_mul=1; go to WAIT.
  - WAIT: if end_mul, go to ADD; otherwise stay in WAIT. end_mul is ignored in every other state.
  - ADD: add=1. If cnt==0, go to DONE. Otherwise cnt=cnt-1 and go to LOAD.
  - DONE: done[sel]=1; go to IDLE. grant clears on entry to IDLE.
- grant and sel are stable from CLEAR through DONE inclusive. grant is 0 in IDLE.
- Strobe outputs are Moore outputs decoded from state. At most one of mac_clear, load_op, begin_mul, add is high in any cycle.
- Latency: with req seen in IDLE at cycle t and end_mul high on first WAIT entry, CLEAR=t+1, LOAD=t+2, RUN=t+3, WAIT=t+4, ADD=t+5, DONE=t+6 for cnt=0. Each extra iteration adds 4 cycles plus extra WAIT cycles.
- Iterations per job = req_len+1, range 1..2^CNT_W. req_len is sampled only at grant; later changes are ignored.
- Requester handshake: hold req until done is seen, then drop req in the next cycle. A req still high in the IDLE cycle after DONE is treated as a new job, but at lowest priority.
- Dropping req mid-job does not abort the job; it completes and done still pulses.
- A req that rises while busy waits; it is arbitrated in the next IDLE.
- end_mul stuck high: WAIT exits after 1 cycle, giving exactly one add per iteration.
- Illegal state encoding: go to IDLE with all outputs 0.

Optional Feature:
- Macro: MAC_WATCHDOG_EN.
- Defined: a wait counter clears on WAIT entry and increments each WAIT cycle without end_mul. If it reaches WDOG_LIMIT, the block skips ADD and goes to DONE with err=1 in the DONE cycle; done[sel] still pulses and the remaining iterations are abandoned.
- Undefined: no counter; WAIT waits indefinitely; err is constant 0.

Test Plan:
- Single job: req[0]=1, len0=9, end_mul 2 cycles after each begin_mul -> 1 mac_clear, 10 load_op, 10 begin_mul, 10 add, then done[0] for one cycle; grant=0001 and sel=0 throughout.
- Latency: req[1]=1, len1=0, end_mul tied high -> grant at t+1, add at t+5, done[1] at t+6, busy low at t+7.
- Fairness: req[0] and req[2] rise together after reset, each held until its done -> requester 0 served first, then 2. With all four held continuously, grant order is 0,1,2,3,0.
- Reset mid-job: assert reset during WAIT of requester 2 -> same-cycle outputs 0 and busy=0; after release with req=1111, first grant goes to requester 0.
- Late request and early drop: req[3] rises while requester 1 is busy -> served next. req[1] dropped during its LOAD -> job still finishes and done[1] pulses.
- Watchdog (MAC_WATCHDOG_EN, WDOG_LIMIT=16): end_mul held 0 -> 16 WAIT cycles, then err=1 and done[sel]=1 in the same cycle, no add pulse. Without the macro, the block stays in WAIT and err=0.
